// File: rtl/sram_axi_data_bridge.sv
// Data-side sram-like responder; each accepted request becomes one
// single-beat AXI3 read (AR/R) or write (AW/W/B), one in flight at a time.
//   sram-like: data_req/wr/size/wstrb/addr/wdata in; addr_ok, data_ok, rdata out
//   AXI3 master: AR/R, AW/W/B channels; fixed ids RD_ID/WR_ID, len 0, INCR
module sram_axi_data_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        data_ok_q, data_ok_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic aw_hs, w_hs, aw_all, w_all;

  // Responses carry no information this block uses.
  logic unused_rsp;
  assign unused_rsp = ^{rid, rresp, rlast, bid, bresp};

  assign data_addr_ok = data_req && (state_q == IDLE);
  assign data_data_ok = data_ok_q;
  assign data_rdata   = data_rdata_q;

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state_q == WR_REQ) && !aw_done_q;

  assign wid     = WR_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign bready  = (state_q == WR_RESP);

  // AW and W may complete in either order or together.
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign aw_all = aw_done_q || aw_hs;
  assign w_all  = w_done_q || w_hs;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    data_rdata_d = data_rdata_q;
    data_ok_d    = 1'b0;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          addr_d  = data_addr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          wdata_d = data_wdata;
          state_d = data_wr ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          data_rdata_d = rdata;
          data_ok_d    = 1'b1;
          state_d      = IDLE;
        end
      end
      WR_REQ: begin
        if (aw_all && w_all) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_all;
          w_done_d  = w_all;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          data_ok_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      data_rdata_q <= '0;
      data_ok_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      data_rdata_q <= data_rdata_d;
      data_ok_q    <= data_ok_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule

// File: tb/tb_sram_axi_data_bridge.sv
// Bench for sram_axi_data_bridge: AXI slave with per-channel delays,
// scoreboard of accepted requests checked at data_ok and at each handshake.
module tb_sram_axi_data_bridge;

  logic        clk, rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;

  sram_axi_data_bridge dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic [3:0]  st;
    logic [31:0] wd;
    logic [31:0] rd;
    int          acc;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] rdq[$];
  logic [31:0] rd_plan[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int last_acc, last_lat, last_ar_lat, resp_cyc;
  int aw_n, w_n;
  int ar_dly, r_dly, aw_dly, w_dly, b_dly;
  int ar_c, r_c, aw_c, w_c, b_c;
  logic force_r;
  logic [31:0] rd_hold;
  logic rst_edge;
  logic ar_pend, aw_pend, w_pend;
  logic [34:0] ar_snap, aw_snap;
  logic [35:0] w_snap;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // AXI slave: ready/valid after a programmable number of cycles.
  initial begin
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; bvalid = 0;
    rid = 4'd0; rdata = '0; rresp = '0; rlast = 1'b1;
    bid = 4'd1; bresp = '0;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    forever begin
      @(posedge clk); #2;
      if (arvalid) begin arready = (ar_c >= ar_dly); ar_c++; end
      else begin arready = 0; ar_c = 0; end
      if (awvalid) begin awready = (aw_c >= aw_dly); aw_c++; end
      else begin awready = 0; aw_c = 0; end
      if (wvalid) begin wready = (w_c >= w_dly); w_c++; end
      else begin wready = 0; w_c = 0; end
      if (rready && rdq.size() > 0) begin
        rvalid = (r_c >= r_dly); r_c++;
      end else begin rvalid = 0; r_c = 0; end
      if (force_r) rvalid = 1'b1;
      rdata = (rdq.size() > 0) ? rdq[0] : 32'h1234_5678;
      rresp = 2'($urandom);
      if (bready) begin bvalid = (b_c >= b_dly); b_c++; end
      else begin bvalid = 0; b_c = 0; end
      bresp = 2'($urandom);
    end
  end

  // Monitor: handshakes and accepts at the edge, output checks at +3.
  initial begin
    int stamp;
    ent_t e;
    rst_edge = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
    rd_hold = '0; aw_n = 0; w_n = 0; resp_cyc = 0;
    forever begin
      @(posedge clk);
      stamp = cyc;
      cyc++;
      rst_edge = rst;
      if (rst) begin
        sb.delete(); rdq.delete();
        rd_hold = '0;
        ar_pend = 0; aw_pend = 0; w_pend = 0;
      end else begin
        if (arvalid && arready) begin
          if (sb.size() == 0) check("ar_orphan", arvalid, 0);
          else begin
            check("ar_kind", sb[0].wr, 0);
            check("ar_fields",
              {araddr, arsize, arid, arlen, arburst,
               arlock, arcache, arprot},
              {sb[0].addr, 1'b0, sb[0].sz, 4'd0, 8'd0, 2'b01,
               2'b00, 4'd0, 3'd0});
            last_ar_lat = stamp - sb[0].acc;
          end
        end
        if (awvalid && awready) begin
          aw_n++;
          if (sb.size() == 0) check("aw_orphan", awvalid, 0);
          else begin
            check("aw_kind", sb[0].wr, 1);
            check("aw_fields",
              {awaddr, awsize, awid, awlen, awburst,
               awlock, awcache, awprot},
              {sb[0].addr, 1'b0, sb[0].sz, 4'd1, 8'd0, 2'b01,
               2'b00, 4'd0, 3'd0});
          end
        end
        if (wvalid && wready) begin
          w_n++;
          if (sb.size() == 0) check("w_orphan", wvalid, 0);
          else check("w_fields", {wdata, wstrb, wid, wlast},
                     {sb[0].wd, sb[0].st, 4'd1, 1'b1});
        end
        if (rvalid && rready) begin
          resp_cyc = stamp;
          if (rdq.size() > 0) void'(rdq.pop_front());
        end
        if (bvalid && bready) begin
          resp_cyc = stamp;
          check("b_after_aw_w", (aw_n == 1) && (w_n == 1), 1);
        end
        if (data_req && data_addr_ok) begin
          e.wr = data_wr; e.addr = data_addr; e.sz = data_size;
          e.st = data_wstrb; e.wd = data_wdata; e.acc = stamp;
          e.rd = (rd_plan.size() > 0) ? rd_plan.pop_front() : $urandom;
          if (!data_wr) rdq.push_back(e.rd);
          sb.push_back(e);
          aw_n = 0; w_n = 0;
          last_acc = stamp;
          n_acc++;
        end
        ar_pend = arvalid && !arready; ar_snap = {araddr, arsize};
        aw_pend = awvalid && !awready; aw_snap = {awaddr, awsize};
        w_pend = wvalid && !wready; w_snap = {wdata, wstrb};
      end
      #3;
      if (rst_edge) begin
        check("reset_outs",
          {arvalid, awvalid, wvalid, rready, bready, data_data_ok},
          6'b0);
        check("reset_data", {data_rdata, araddr, wdata, wstrb, arsize},
              '0);
      end else if (!rst) begin
        if (sb.size() == 0) check("ok_orphan", data_data_ok, 0);
        if (data_data_ok && sb.size() > 0) begin
          e = sb.pop_front();
          check("ok_rdata", data_rdata, e.wr ? rd_hold : e.rd);
          check("ok_after_resp", cyc, resp_cyc + 1);
          if (!e.wr) rd_hold = e.rd;
          last_lat = cyc - e.acc;
        end else begin
          check("rdata_hold", data_rdata, rd_hold);
        end
        check("addr_ok", data_addr_ok, data_req && (sb.size() == 0));
        if (sb.size() == 0) check("rready_idle", rready, 0);
        if (ar_pend)
          check("ar_stable", {arvalid, araddr, arsize}, {1'b1, ar_snap});
        if (aw_pend)
          check("aw_stable", {awvalid, awaddr, awsize}, {1'b1, aw_snap});
        if (w_pend)
          check("w_stable", {wvalid, wdata, wstrb}, {1'b1, w_snap});
        if (awvalid) check("aw_drop", aw_n, 0);
        if (wvalid) check("w_drop", w_n, 0);
        if (bready) check("b_gate", (aw_n == 1) && (w_n == 1), 1);
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] sz,
                       input logic [3:0] st, input logic [31:0] a,
                       input logic [31:0] wd);
    int n0;
    n0 = n_acc;
    data_req = 1'b1; data_wr = wr; data_size = sz;
    data_wstrb = st; data_addr = a; data_wdata = wd;
    for (int k = 0; k < 200 && n_acc == n0; k++) begin
      @(posedge clk); #1;
    end
    check("accept_timeout", n_acc != n0, 1);
  endtask

  task automatic idle();
    data_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("done_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int a1, a2;
    logic w;
    rst = 1; force_r = 0;
    data_req = 0; data_wr = 0; data_size = 0;
    data_wstrb = 0; data_addr = 0; data_wdata = 0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // zero-wait read word
    rd_plan.push_back(32'hDEAD_BEEF);
    issue(0, 2'd2, 4'hf, 32'h1C00_0100, 32'h0);
    idle();
    wait_done();
    check("t1_ar_lat", last_ar_lat, 1);
    check("t1_lat", last_lat, 3);
    check("t1_rdata", data_rdata, 32'hDEAD_BEEF);

    // write byte, W accepted three cycles before AW
    aw_dly = 3;
    issue(1, 2'd0, 4'b1000, 32'h8000_0003, 32'h1100_0000);
    idle();
    wait_done();
    aw_dly = 0;
    check("t2_lat", last_lat, 6);

    // zero-wait write word
    issue(1, 2'd2, 4'hf, 32'h8000_0010, 32'hCAFE_F00D);
    idle();
    wait_done();
    check("t2b_lat", last_lat, 3);
    check("t2b_rdata", data_rdata, 32'hDEAD_BEEF);

    // slow arready with request held high
    ar_dly = 5;
    issue(0, 2'd1, 4'h3, 32'h0000_0042, 32'h0);
    issue(0, 2'd2, 4'hf, 32'h0000_0100, 32'h0);
    check("t3_lat_first", last_lat, 8);
    idle();
    wait_done();
    check("t3_lat_second", last_lat, 8);
    ar_dly = 0;

    // back-to-back read then write
    rd_plan.push_back(32'h0BAD_F00D);
    issue(0, 2'd2, 4'hf, 32'h0000_0200, 32'h0);
    a1 = last_acc;
    issue(1, 2'd1, 4'b0011, 32'h0000_0204, 32'h0000_BEEF);
    a2 = last_acc;
    idle();
    check("t4_b2b", a2 - a1, 3);
    wait_done();
    check("t4_hold", data_rdata, 32'h0BAD_F00D);

    // reset while waiting for R
    r_dly = 20;
    rd_plan.push_back(32'h5555_AAAA);
    issue(0, 2'd2, 4'hf, 32'h0000_0300, 32'h0);
    idle();
    for (int k = 0; k < 20 && !rready; k++) begin
      @(posedge clk); #1;
    end
    check("t5_rready", rready, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    r_dly = 0;
    repeat (5) begin @(posedge clk); #1; end
    rd_plan.push_back(32'hA5A5_0001);
    issue(0, 2'd2, 4'hf, 32'h0000_0400, 32'h0);
    idle();
    wait_done();
    check("t5_lat", last_lat, 3);
    check("t5_rdata", data_rdata, 32'hA5A5_0001);

    // spurious rvalid while idle
    force_r = 1;
    repeat (4) begin
      @(posedge clk); #1;
      check("t6_rready", rready, 0);
      check("t6_ok", data_data_ok, 0);
    end
    force_r = 0;
    check("t6_hold", data_rdata, 32'hA5A5_0001);

    // random mix
    repeat (40) begin
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      w = 1'($urandom);
      issue(w, 2'($urandom_range(0, 2)), 4'($urandom),
            $urandom, $urandom);
      if ($urandom_range(0, 1) == 0) begin
        idle();
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    idle();
    wait_done();
    repeat (3) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_axi_data_bridge.md
Name: sram_axi_data_bridge

Overview:
- Responder end of the CPU data-side sram-like interface; the MEM stage issues requests here and RDW consumes the returned data_ok/rdata.
- Converts each accepted sram-like request into a single-beat AXI3 read (AR/R) or write (AW/W/B) transaction.
- At most one transaction is in flight, so responses return strictly in request order.

Parameters:
RD_ID, 4'd0, constant arid driven on AR.
WR_ID, 4'd1, constant awid/wid driven on AW/W.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
data_req  in  1  sram-like request valid
data_wr  in  1  1=write, 0=read
data_size  in  2  0=byte, 1=half, 2=word
data_wstrb  in  4  byte enables (write)
data_addr  in  32  byte address
data_wdata  in  32  write data
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  response pulse (read data valid / write complete)
data_rdata  out  32  read data
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI AR
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R
rready  out  1
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AXI AW
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI W
wready  in  1
bid/bresp/bvalid  in  4/2/1  AXI B
bready  out  1

Behaviour:
- Constants: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1, arid=RD_ID, awid=wid=WR_ID. arsize=awsize={1'b0,data_size} as captured.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- data_addr_ok = data_req && state==IDLE; combinational.
- On accept, latch addr, size, wstrb, wdata. Next state is RD_ADDR if wr=0, else WR_REQ.
- RD_ADDR:
  - arvalid=1, araddr/arsize from latch.
  - arvalid/araddr/arsize stay stable until arready.
  - On arvalid&&arready -> RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: latch rdata into data_rdata, -> IDLE.
  - data_data_ok=1 in the following cycle only.
  - rresp is ignored.
- WR_REQ:
  - awvalid and wvalid are both asserted on entry.
  - aw_done and w_done flags track each handshake independently.
  - awvalid drops after its handshake; wvalid drops after its handshake.
  - When both handshakes are done (same or different cycles) -> WR_RESP; clear both flags.
- WR_RESP:
  - bready=1.
  - On bvalid -> IDLE.
  - data_data_ok=1 in the following cycle.
  - data_rdata is unchanged.
  - bresp is ignored.
- data_data_ok is a registered one-cycle pulse. A new request may be accepted in the same cycle data_data_ok is high, since state is already IDLE.
- data_rdata holds its last read value until the next read response. It is never cleared by writes.
- Latency, zero-wait slave:
  - Read: accept cycle 0, AR handshake cycle 1, R handshake cycle 2, data_ok cycle 3.
  - Write: AW/W handshake cycle 1, B handshake cycle 2, data_ok cycle 3.
- AXI valid signals never deassert before handshake. rvalid/bvalid arriving in a state that does not expect them are not accepted, because rready/bready=0 there.
- Pipeline flushes do not affect this block. The outstanding transaction always completes and returns data_ok; the consumer discards it.
- Reset:
  - state=IDLE; all valid/ready outputs=0; data_data_ok=0; data_rdata=0; latches=0.
  - Reset mid-transaction abandons it; no data_ok is produced.

Test Plan:
- Read word, addr 0x1C000100, arready and rvalid immediate, rdata=0xDEADBEEF -> addr_ok cycle 0; arvalid cycle 1 with araddr=0x1C000100, arsize=2; data_data_ok cycle 3 with data_rdata=0xDEADBEEF.
- Write byte, addr 0x80000003, wstrb=4'b1000, wdata=0x11000000; wready 3 cycles before awready -> wvalid drops after the W handshake; awvalid is held until arrival; WR_RESP only after both; data_ok one cycle after bvalid.
- arready delayed 5 cycles -> arvalid/araddr stable throughout; data_req held high gets addr_ok=0 until the data_ok cycle.
- Back-to-back read then write with data_req constant 1 -> second addr_ok coincides with first data_data_ok; write data_ok leaves data_rdata unchanged.
- rst asserted in RD_DATA before rvalid -> next cycle all outputs 0, state IDLE, no data_data_ok; a subsequent read completes normally.
- rvalid asserted spuriously while IDLE -> rready=0, no data_ok, data_rdata unchanged.
